// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, 1 or 2 stop bits, busyTx high for the whole frame.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       txEnable,
    input  logic [7:0] txData,
    output logic       tx,
    output logic       busyTx
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [15:0] BAUD_MAX  = 16'(CLKS_PER_BIT - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

    state_t      stateReg, stateNext;
    logic [15:0] baudReg, baudNext;
    logic [2:0]  bitIdxReg, bitIdxNext;
    logic        stopIdxReg, stopIdxNext;
    logic [7:0]  shiftReg, shiftNext;
    logic        txReg, txNext;
    logic        busyReg, busyNext;
    logic        bitEnd;
`ifdef UART_TX_PARITY_EN
    logic        parityReg, parityNext;
`endif

    assign tx     = txReg;
    assign busyTx = busyReg;
    assign bitEnd = (baudReg == BAUD_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg   <= IDLE;
            baudReg    <= '0;
            bitIdxReg  <= '0;
            stopIdxReg <= 1'b0;
            shiftReg   <= '0;
            txReg      <= 1'b1;
            busyReg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parityReg  <= 1'b0;
`endif
        end else begin
            stateReg   <= stateNext;
            baudReg    <= baudNext;
            bitIdxReg  <= bitIdxNext;
            stopIdxReg <= stopIdxNext;
            shiftReg   <= shiftNext;
            txReg      <= txNext;
            busyReg    <= busyNext;
`ifdef UART_TX_PARITY_EN
            parityReg  <= parityNext;
`endif
        end
    end

    always_comb begin
        stateNext   = stateReg;
        bitIdxNext  = bitIdxReg;
        stopIdxNext = stopIdxReg;
        shiftNext   = shiftReg;
        txNext      = txReg;
        busyNext    = busyReg;
        // Every state change happens on a bit end, so wrapping here also clears on change.
        baudNext    = bitEnd ? 16'd0 : baudReg + 16'd1;
`ifdef UART_TX_PARITY_EN
        parityNext  = parityReg;
`endif

        case (stateReg)
            IDLE: begin
                baudNext = 16'd0;
                txNext   = 1'b1;
                busyNext = 1'b0;
                if (txEnable) begin
                    stateNext   = START;
                    shiftNext   = txData;
                    bitIdxNext  = 3'd0;
                    stopIdxNext = 1'b0;
                    txNext      = 1'b0;
                    busyNext    = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parityNext  = ^txData;
`endif
                end
            end
            START: begin
                if (bitEnd) begin
                    stateNext = DATA;
                    txNext    = shiftReg[0];
                end
            end
            DATA: begin
                if (bitEnd) begin
                    shiftNext = {1'b0, shiftReg[7:1]};
                    if (bitIdxReg == 3'd7) begin
                        bitIdxNext = 3'd0;
`ifdef UART_TX_PARITY_EN
                        stateNext  = PARITY;
                        txNext     = parityReg;
`else
                        stateNext  = STOP;
                        txNext     = 1'b1;
`endif
                    end else begin
                        bitIdxNext = bitIdxReg + 3'd1;
                        txNext     = shiftReg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bitEnd) begin
                    stateNext = STOP;
                    txNext    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bitEnd) begin
                    if (stopIdxReg == STOP_LAST) begin
                        stateNext   = IDLE;
                        stopIdxNext = 1'b0;
                        busyNext    = 1'b0;
                        txNext      = 1'b1;
                    end else begin
                        stopIdxNext = 1'b1;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                txNext    = 1'b1;
                busyNext  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-cycle comparison of tx/busyTx against a bit-list frame model.
// Define UART_TX_PARITY_EN to exercise the parity build with two stop bits.
module tb_uart_tx;

    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P  = 1;
    localparam int SB = 2;
`else
    localparam int P  = 0;
    localparam int SB = 1;
`endif
    localparam int NBITS = 1 + 8 + P + SB;
    localparam int FRAME = NBITS * C;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       txEnable = 1'b0;
    logic [7:0] txData = 8'h00;
    logic       tx;
    logic       busyTx;

    int checks = 0;
    int passes = 0;

    uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(SB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .txEnable(txEnable),
        .txData(txData),
        .tx(tx),
        .busyTx(busyTx)
    );

    always #5 clk = ~clk;

    // Expected line level for bit slot k of a frame carrying d.
    function automatic logic exp_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (P == 1 && k == 9) return ($countones(d) % 2) == 1;
        return 1'b1;
    endfunction

    task automatic check_idle(input string name);
        checks++;
        if (tx !== 1'b1) $display("FAIL %s tx=%b expected=1", name, tx);
        else passes++;
        checks++;
        if (busyTx !== 1'b0) $display("FAIL %s busyTx=%b expected=0", name, busyTx);
        else passes++;
    endtask

    // Entered just after a negedge with txEnable=1/txData=d driven for the load edge.
    task automatic frame_check(input logic [7:0] d, input int pokeAt, input bit holdEn,
                               input bit chain, input logic [7:0] nextD);
        int errs = 0;
        logic expTx, expBusy;
        for (int i = 0; i <= FRAME; i++) begin
            @(negedge clk);
            expTx   = (i < FRAME) ? exp_bit(d, i / C) : 1'b1;
            expBusy = (i < FRAME);
            checks++;
            if (tx !== expTx) begin
                $display("FAIL frame_tx d=%h cyc=%0d tx=%b expected=%b", d, i, tx, expTx);
                errs++;
            end else passes++;
            checks++;
            if (busyTx !== expBusy) begin
                $display("FAIL frame_busy d=%h cyc=%0d busyTx=%b expected=%b", d, i, busyTx, expBusy);
                errs++;
            end else passes++;
            txData   = 8'($urandom);
            txEnable = holdEn && (i < FRAME);
            if (i == pokeAt - 1) begin
                txEnable = 1'b1;
                txData   = 8'hFF;
            end
            if (i == FRAME && chain) begin
                txEnable = 1'b1;
                txData   = nextD;
            end
        end
        $display("frame d=%h poke=%0d hold=%0d chain=%0d errors=%0d", d, pokeAt, holdEn, chain, errs);
    endtask

    task automatic start_load(input logic [7:0] d);
        @(negedge clk);
        check_idle("pre_load_idle");
        txEnable = 1'b1;
        txData   = d;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_idle("reset_async");
        repeat (3) begin
            @(negedge clk);
            check_idle("reset_hold");
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset_release");
        $display("reset test done");
    endtask

    task automatic test_single_frame;
        start_load(8'hA5);
        frame_check(8'hA5, -1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_busy_collision;
        start_load(8'h3C);
        frame_check(8'h3C, 10, 1'b0, 1'b0, 8'h00);
        repeat (2) begin
            @(negedge clk);
            check_idle("collision_no_second_frame");
        end
    endtask

    task automatic test_held_enable;
        logic [7:0] d = 8'($urandom);
        start_load(d);
        frame_check(d, -1, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        check_idle("held_enable_single_load");
    endtask

    task automatic test_back_to_back;
        start_load(8'h01);
        frame_check(8'h01, -1, 1'b0, 1'b1, 8'h80);
        frame_check(8'h80, -1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset_midframe;
        start_load(8'h55);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            txEnable = 1'b0;
            checks++;
            if (tx !== exp_bit(8'h55, i / C))
                $display("FAIL midframe_tx cyc=%0d tx=%b expected=%b", i, tx, exp_bit(8'h55, i / C));
            else passes++;
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle("midframe_reset_async");
        repeat (2) begin
            @(negedge clk);
            check_idle("midframe_reset_hold");
        end
        rst_n = 1'b1;
        start_load(8'h0F);
        frame_check(8'h0F, -1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_parity_bytes;
        start_load(8'h07);
        frame_check(8'h07, -1, 1'b0, 1'b0, 8'h00);
        start_load(8'h03);
        frame_check(8'h03, -1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_random_frames;
        logic [7:0] d, nd;
        bit chained = 1'b0;
        d = 8'($urandom);
        for (int n = 0; n < 8; n++) begin
            bit chainNow = ($urandom_range(0, 1) == 1) && (n < 7);
            nd = 8'($urandom);
            if (!chained) start_load(d);
            frame_check(d, -1, 1'b0, chainNow, nd);
            chained = chainNow;
            d = nd;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_single_frame;
        test_busy_collision;
        test_held_enable;
        test_back_to_back;
        test_reset_midframe;
        test_parity_bytes;
        test_random_frames;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
